// File: rtl/sigmoid_pkg.sv
// Shared Q8.8 constants and FSM state type for the sigmoid/logit datapath.
package sigmoid_pkg;

  localparam int FRAC_W = 8;

  localparam logic [15:0] ONE     = 16'h0100;
  localparam logic [15:0] HALF    = 16'h0080;
  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/logit_normalizer.sv
// Leading-one normaliser: shifts z left one bit per step until its MSB is set,
// counting the shifts in n (the integer part of the logit).
module logit_normalizer #(
  parameter int W         = 8,
  parameter int MAX_SHIFT = 7,
  parameter int NW        = $clog2(MAX_SHIFT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena_i,
  input  logic          load_i,
  input  logic [W-1:0]  z_i,
  input  logic          step_i,
  output logic          done_o,
  output logic [NW-1:0] n_o,
  output logic [W-1:0]  g_o
);

  logic [W-1:0]  z_q, z_d;
  logic [NW-1:0] n_q, n_d;

  always_comb begin
    z_d = z_q;
    n_d = n_q;
    if (load_i) begin
      z_d = z_i;
      n_d = '0;
    end else if (step_i && !z_q[W-1]) begin
      z_d = {z_q[W-2:0], 1'b0};
      n_d = n_q + NW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z_q <= '0;
      n_q <= '0;
    end else if (ena_i) begin
      z_q <= z_d;
      n_q <= n_d;
    end
  end

  assign done_o = z_q[W-1];
  assign n_o    = n_q;
  assign g_o    = z_q;

endmodule

// File: rtl/sigmoid_inverse_seq.sv
// Iterative inverse of the shift-based sigmoid: unsigned Q8.8 probability in,
// signed Q8.8 logit out, behind valid/ready handshakes on both sides.
module sigmoid_inverse_seq #(
  parameter int DATA_W    = 16,
  parameter int FRAC_W    = 8,
  parameter int MAX_SHIFT = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_y,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_x,
  output logic              out_sat,
  input  logic              out_ready,
  output logic              busy
);

  import sigmoid_pkg::*;

  localparam int NW = $clog2(MAX_SHIFT + 1);

  state_e              state_q;
  logic                pos_q;
  logic [DATA_W-1:0]   out_x_q;
  logic                out_sat_q;

  logic                accept;
  logic                y_zero;
  logic                y_over;
  logic                in_pos;
  logic [FRAC_W-1:0]   y_lo;
  logic [FRAC_W-1:0]   z_load;
  logic                norm_load;
  logic                norm_done;
  logic [NW-1:0]       norm_n;
  logic [FRAC_W-1:0]   norm_g;
  logic [FRAC_W-1:0]   frac;
  logic [DATA_W-1:0]   mag;

  assign in_ready  = ena && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_x     = out_x_q;
  assign out_sat   = out_sat_q;

  assign accept = in_valid && in_ready;
  assign y_zero = (in_y == '0);
  assign y_over = (in_y >= ONE);
  assign in_pos = (in_y >= HALF);
  assign y_lo   = in_y[FRAC_W-1:0];
  // 256 - y folds to the 8-bit negation, which also keeps 0x80 -> 0x80.
  assign z_load = in_pos ? -y_lo : y_lo;

  assign norm_load = accept && !y_zero && !y_over;

  logit_normalizer #(
    .W         (FRAC_W),
    .MAX_SHIFT (MAX_SHIFT),
    .NW        (NW)
  ) u_norm (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena_i  (ena),
    .load_i (norm_load),
    .z_i    (z_load),
    .step_i (state_q == NORM),
    .done_o (norm_done),
    .n_o    (norm_n),
    .g_o    (norm_g)
  );

  // g in [128,192) gives (g-128)<<2; the upper half is clamped to all-ones.
  assign frac = (norm_g[FRAC_W-1 -: 2] == 2'b10) ? {norm_g[FRAC_W-3:0], 2'b00}
                                                  : {FRAC_W{1'b1}};
  assign mag  = DATA_W'({norm_n, frac});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pos_q     <= 1'b0;
      out_x_q   <= '0;
      out_sat_q <= 1'b0;
    end else if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (y_zero) begin
              out_x_q   <= SAT_NEG;
              out_sat_q <= 1'b1;
              state_q   <= DONE;
            end else if (y_over) begin
              out_x_q   <= SAT_POS;
              out_sat_q <= 1'b1;
              state_q   <= DONE;
            end else begin
              pos_q   <= in_pos;
              state_q <= NORM;
            end
          end
        end
        NORM: begin
          if (norm_done) begin
            out_x_q   <= pos_q ? mag : -mag;
            out_sat_q <= 1'b0;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sigmoid_inverse_seq.sv
// Randomised and directed bench for sigmoid_inverse_seq against an arithmetic
// logit reference model.
module tb_sigmoid_inverse_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        in_valid;
  logic [15:0] in_y;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_x;
  logic        out_sat;
  logic        out_ready;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sigmoid_inverse_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_y      (in_y),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_x     (out_x),
    .out_sat   (out_sat),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inverse of sigma(x) = 1 - ((0.5 + frac/4) >> int), mirrored for y < 0.5.
  task automatic ref_logit(input logic [15:0] y, output logic [15:0] x,
                           output logic sat, output int lat);
    int z, n, g, fr, mag;
    if (y == 16'h0000) begin
      x = 16'h8000; sat = 1'b1; lat = 1;
    end else if (y >= 16'h0100) begin
      x = 16'h7FFF; sat = 1'b1; lat = 1;
    end else begin
      z   = (y >= 16'h0080) ? 256 - int'(y) : int'(y);
      n   = 8 - $clog2(z + 1);
      g   = z * (1 << n);
      fr  = (g < 192) ? (g - 128) * 4 : 255;
      mag = n * 256 + fr;
      x   = (y >= 16'h0080) ? 16'(mag) : 16'(65536 - mag);
      sat = 1'b0;
      lat = n + 2;
    end
  endtask

  task automatic run_txn(input logic [15:0] y, input int gap_at, input int gap_len);
    logic [15:0] ex;
    logic        es;
    int          el;
    int          lat;
    ref_logit(y, ex, es, el);
    el = el + gap_len;
    @(negedge clk);
    check_eq("in_ready_idle", in_ready, 1);
    in_y      = y;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      if (lat == gap_at) ena = 1'b0;
      if (lat == gap_at + gap_len) ena = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    ena = 1'b1;
    check_eq("out_valid", out_valid, 1);
    check_eq("out_x", out_x, ex);
    check_eq("out_sat", out_sat, es);
    check_eq("latency", lat, el);
    check_eq("in_ready_done", in_ready, 0);
    $display("txn y=%04h x=%04h sat=%0d lat=%0d exp_x=%04h exp_sat=%0d exp_lat=%0d",
             y, out_x, out_sat, lat, ex, es, el);
    @(posedge clk);
    @(negedge clk);
    check_eq("out_valid_drop", out_valid, 0);
    check_eq("busy_idle", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] directed [9];
    int w;
    directed = '{16'h0080, 16'h00C0, 16'h00B0, 16'h0040, 16'h00FF,
                 16'h0001, 16'h0000, 16'h0100, 16'hFFFF};

    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; in_y = 16'h0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_out_x", out_x, 0);
    check_eq("rst_out_sat", out_sat, 0);
    rst_n = 1'b1;
    @(negedge clk);
    ena = 1'b0;
    #1;
    check_eq("in_ready_ena_low", in_ready, 0);
    ena = 1'b1;

    foreach (directed[i]) run_txn(directed[i], -1, 0);

    for (int i = 0; i < 40; i++) begin
      int r;
      logic [15:0] y;
      r = $urandom_range(0, 9);
      if (r == 0)      y = 16'($urandom_range(256, 65535));
      else if (r == 1) y = 16'h0000;
      else             y = 16'($urandom_range(1, 255));
      run_txn(y, -1, 0);
    end

    // Back-pressure: result must hold and a second word must be ignored.
    @(negedge clk);
    in_y = 16'h00C0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin
      @(posedge clk);
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_out_valid", out_valid, 1);
      check_eq("bp_out_x", out_x, 16'h0100);
      check_eq("bp_in_ready", in_ready, 0);
      in_y = 16'h0040; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("bp_release_valid", out_valid, 0);
    check_eq("bp_release_ready", in_ready, 1);
    check_eq("bp_release_busy", busy, 0);
    check_eq("bp_held_x", out_x, 16'h0100);
    $display("txn backpressure y=00c0 x=%04h", out_x);

    // Reset mid-NORM discards the partial result.
    in_y = 16'h00FF; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("midnorm_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_out_x", out_x, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    repeat (12) @(negedge clk);
    check_eq("midrst_stays_idle", out_valid, 0);
    $display("txn reset_mid_norm y=00ff x=%04h", out_x);

    run_txn(16'h00FF, -1, 0);
    run_txn(16'h00FF, 3, 3);
    run_txn(16'h00C0, 1, 2);
    run_txn(16'h0001, 5, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
